// File: rtl/adbg_jsp_apb_host.sv
// rtl/adbg_jsp_apb_host.sv - APB master draining/filling the JSP 16550 window as rx/tx byte streams.
// Optional macro ADBG_JSP_HOST_INT_EN: write IER_VAL at init and poll LSR immediately on int_i.
module adbg_jsp_apb_host #(
    parameter int         POLL_DLY = 16,
    parameter logic [3:0] IER_VAL  = 4'h3
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    output logic       PSEL,
    output logic       PENABLE,
    output logic [2:0] PADDR,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic       int_i,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       err_o
);
`ifdef ADBG_JSP_HOST_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif
    localparam logic [7:0] IER_WR = INT_EN ? {4'h0, IER_VAL} : 8'h00;
    localparam int CW = (POLL_DLY > 1) ? $clog2(POLL_DLY + 1) : 1;
    localparam logic [CW-1:0] POLL_LD = CW'(POLL_DLY);

    typedef enum logic [2:0] {
        INIT_LCR, INIT_IER, IDLE, LSR_RD, RX_RD, TX_WR
    } state_t;

    state_t        state_q, state_d;
    logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [2:0]    paddr_q, paddr_d;
    logic [7:0]    pwdata_q, pwdata_d, rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d, last_rx_q, last_rx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done, setup, rx_ok, tx_ok;
    logic [7:0]    lsr;

    assign done  = psel_q & penable_q & PREADY;
    // An errored LSR read reads as all-zero so the master falls back to IDLE.
    assign lsr   = PSLVERR ? 8'h00 : PRDATA;
    assign rx_ok = lsr[0] & ~rx_valid_q;
    assign tx_ok = lsr[5] & tx_valid;

    always_comb begin
        state_d    = state_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_ready;
        last_rx_d  = last_rx_q;
        cnt_d      = cnt_q;
        setup      = 1'b0;
        if (state_q == IDLE) begin
            if (cnt_q == '0 || (INT_EN && int_i)) begin
                state_d = LSR_RD;
                setup   = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (!psel_q) begin
            setup = 1'b1;
        end else if (!penable_q) begin
            penable_d = 1'b1;
        end else if (PREADY) begin
            case (state_q)
                INIT_LCR: state_d = INIT_IER;
                INIT_IER: state_d = IDLE;
                LSR_RD: begin
                    last_rx_d = 1'b0;
                    if (rx_ok && !(tx_ok && last_rx_q)) state_d = RX_RD;
                    else if (tx_ok)                     state_d = TX_WR;
                    else                                state_d = IDLE;
                end
                RX_RD: begin
                    state_d = LSR_RD;
                    if (!PSLVERR) begin
                        rx_data_d  = PRDATA;
                        rx_valid_d = 1'b1;
                        last_rx_d  = 1'b1;
                    end
                end
                default: state_d = LSR_RD;
            endcase
            if (state_d == IDLE) begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                cnt_d     = POLL_LD;
            end else begin
                setup = 1'b1;
            end
        end
        if (setup) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            case (state_d)
                INIT_LCR: begin paddr_d = 3'd3; pwrite_d = 1'b1; pwdata_d = 8'h03;   end
                INIT_IER: begin paddr_d = 3'd1; pwrite_d = 1'b1; pwdata_d = IER_WR;  end
                LSR_RD:   begin paddr_d = 3'd5; pwrite_d = 1'b0; pwdata_d = 8'h00;   end
                RX_RD:    begin paddr_d = 3'd0; pwrite_d = 1'b0; pwdata_d = 8'h00;   end
                TX_WR:    begin paddr_d = 3'd0; pwrite_d = 1'b1; pwdata_d = tx_data; end
                default:  begin paddr_d = paddr_q; pwrite_d = pwrite_q; pwdata_d = pwdata_q; end
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= INIT_LCR;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= 3'd0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            last_rx_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            last_rx_q  <= last_rx_d;
            cnt_q      <= cnt_d;
        end
    end

    assign PSEL     = psel_q;
    assign PENABLE  = penable_q;
    assign PADDR    = paddr_q;
    assign PWRITE   = pwrite_q;
    assign PWDATA   = pwdata_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    // Both pulses coincide with the completing access cycle.
    assign tx_ready = done && (state_q == TX_WR);
    assign err_o    = done & PSLVERR;
endmodule

// File: tb/tb_adbg_jsp_apb_host.sv
// tb/tb_adbg_jsp_apb_host.sv - directed bench for adbg_jsp_apb_host with a small 16550 slave model.
module tb_adbg_jsp_apb_host;
    localparam int PD = 2;
`ifdef ADBG_JSP_HOST_INT_EN
    localparam logic [7:0] IER_EXP = 8'h03;
`else
    localparam logic [7:0] IER_EXP = 8'h00;
`endif

    typedef struct packed {
        logic [2:0] a;
        logic       w;
        logic [7:0] d;
        logic       e;
    } xfer_t;

    logic       PCLK = 1'b0, PRESETn = 1'b0;
    logic       PSEL, PENABLE, PWRITE;
    logic [2:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA = 8'h00;
    logic       PREADY = 1'b0, PSLVERR = 1'b0;
    logic       int_i = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready = 1'b0, err_o;

    always #5 PCLK = ~PCLK;

    adbg_jsp_apb_host #(.POLL_DLY(PD), .IER_VAL(4'h3)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .int_i(int_i), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .err_o(err_o)
    );

    int n_checks = 0, n_fail = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave model: RBR pops a byte queue, LSR[0] = queue non-empty, LSR[6:5] = tx_space.
    int         wait_n = 0, wcnt = 0, stab_err = 0;
    logic       tx_space = 1'b0, err_on_rbr = 1'b0;
    logic [7:0] rx_q[$];
    xfer_t      log_q[$];
    logic [2:0] su_a;
    logic       su_w;
    logic [7:0] su_d;

    always @(negedge PCLK) begin
        if (!PRESETn || !PSEL) begin
            PREADY = 1'b0; PSLVERR = 1'b0; wcnt = 0;
        end else if (!PENABLE) begin
            PREADY = 1'b0; PSLVERR = 1'b0; wcnt = 0;
            su_a = PADDR; su_w = PWRITE; su_d = PWDATA;
        end else if (wcnt < wait_n) begin
            wcnt++;
        end else begin
            PREADY  = 1'b1;
            PSLVERR = 1'b0;
            if ({PADDR, PWRITE, PWDATA} != {su_a, su_w, su_d}) stab_err++;
            if (!PWRITE && PADDR == 3'd5) begin
                PRDATA = {1'b0, tx_space, tx_space, 4'b0, rx_q.size() != 0};
            end else if (!PWRITE && PADDR == 3'd0) begin
                PRDATA  = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
                PSLVERR = err_on_rbr;
            end
            log_q.push_back({PADDR, PWRITE, PWRITE ? PWDATA : PRDATA, PSLVERR});
        end
    end

    int         tx_cnt = 0, err_cnt = 0, rx_hi = 0, idle_run = 0, last_idle = 0;
    logic [7:0] got_q[$];
    always @(negedge PCLK) begin
        #2;
        if (tx_ready) tx_cnt++;
        if (err_o) err_cnt++;
        if (rx_valid) rx_hi++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (!PRESETn) idle_run = 0;
        else if (!PSEL) idle_run++;
        else if (idle_run != 0) begin last_idle = idle_run; idle_run = 0; end
    end

    function automatic xfer_t get(int i);
        if (i >= 0 && i < log_q.size()) return log_q[i];
        return '0;
    endfunction
    function automatic logic [7:0] got_at(int i);
        if (i >= 0 && i < got_q.size()) return got_q[i];
        return 8'h00;
    endfunction
    function automatic int find_data(int start);
        for (int i = (start < 0 ? 0 : start); i < log_q.size(); i++)
            if (log_q[i].a == 3'd0) return i;
        return -1;
    endfunction
    function automatic int count_addr(logic [2:0] a, logic w);
        int n = 0;
        foreach (log_q[i]) if (log_q[i].a == a && log_q[i].w == w) n++;
        return n;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(negedge PCLK); #1; end
    endtask

    int i0, i1, i2, t0, g0, h0, e0;
    initial begin
        tick(3);
        check("rst_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
        check("rst_strm", {tx_ready, rx_valid, err_o, rx_data}, 0);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        check("first_setup", {PSEL, PENABLE, PADDR, PWRITE, PWDATA}, {1'b1, 1'b0, 3'd3, 1'b1, 8'h03});
        for (int k = 0; k < 100 && log_q.size() < 3; k++) tick(1);
        check("init_lcr", get(0), {3'd3, 1'b1, 8'h03, 1'b0});
        check("init_ier", get(1), {3'd1, 1'b1, IER_EXP, 1'b0});
        check("poll_rd", {get(2).a, get(2).w}, {3'd5, 1'b0});
        check("idle_len", last_idle, PD + 1);

        tick(1);
        log_q.delete(); rx_ready = 1'b1; h0 = rx_hi;
        rx_q.push_back(8'h41);
        for (int k = 0; k < 100 && got_q.size() < 1; k++) tick(1);
        tick(6);
        check("rx_byte", got_at(0), 8'h41);
        check("rx_hi_1cyc", rx_hi - h0, 1);
        i0 = find_data(0);
        check("rx_rd", get(i0), {3'd0, 1'b0, 8'h41, 1'b0});
        check("rx_then_lsr", {get(i0 + 1).a, get(i0 + 1).w}, {3'd5, 1'b0});

        rx_ready = 1'b0; log_q.delete();
        rx_q.push_back(8'h11); rx_q.push_back(8'h22);
        tick(60);
        check("hold_one_rd", count_addr(3'd0, 1'b0), 1);
        check("hold_valid", {rx_valid, rx_data}, {1'b1, 8'h11});
        check("hold_polls", count_addr(3'd5, 1'b0) >= 3, 1);
        rx_ready = 1'b1;
        for (int k = 0; k < 100 && got_q.size() < 3; k++) tick(1);
        check("hold_b1", got_at(1), 8'h11);
        check("hold_b2", got_at(2), 8'h22);

        wait_n = 3; tx_space = 1'b1; log_q.delete(); t0 = tx_cnt;
        tx_data = 8'h5A; tx_valid = 1'b1;
        for (int k = 0; k < 100 && tx_cnt == t0; k++) tick(1);
        tx_valid = 1'b0;
        tick(10);
        check("tx_pulses", tx_cnt - t0, 1);
        i0 = find_data(0);
        check("tx_wr", get(i0), {3'd0, 1'b1, 8'h5A, 1'b0});
        check("tx_single", find_data(i0 + 1), -1);
        wait_n = 0;

        for (int k = 0; k < 100 && PSEL; k++) tick(1);
        log_q.delete(); g0 = got_q.size(); t0 = tx_cnt;
        rx_q.push_back(8'h77); rx_q.push_back(8'h78);
        tx_data = 8'hC3; tx_valid = 1'b1;
        for (int k = 0; k < 100 && tx_cnt == t0; k++) tick(1);
        tx_valid = 1'b0;
        for (int k = 0; k < 100 && got_q.size() < g0 + 2; k++) tick(1);
        tick(4);
        i0 = find_data(0); i1 = find_data(i0 + 1); i2 = find_data(i1 + 1);
        check("fair_rx1", get(i0), {3'd0, 1'b0, 8'h77, 1'b0});
        check("fair_lsr", {get(i0 + 1).a, get(i0 + 1).w}, {3'd5, 1'b0});
        check("fair_adj", i1 - i0, 2);
        check("fair_tx", get(i1), {3'd0, 1'b1, 8'hC3, 1'b0});
        check("fair_rx2", get(i2), {3'd0, 1'b0, 8'h78, 1'b0});

        log_q.delete(); e0 = err_cnt; h0 = rx_hi; g0 = got_q.size();
        err_on_rbr = 1'b1;
        rx_q.push_back(8'h99);
        for (int k = 0; k < 100 && count_addr(3'd0, 1'b0) < 1; k++) tick(1);
        tick(4);
        err_on_rbr = 1'b0;
        check("err_pulse", err_cnt - e0, 1);
        check("err_no_valid", rx_hi - h0, 0);
        check("err_no_byte", got_q.size() - g0, 0);

        wait_n = 5; t0 = tx_cnt;
        tx_data = 8'hAB; tx_valid = 1'b1;
        for (int k = 0; k < 100 && !(PSEL && PENABLE && PWRITE && PADDR == 3'd0); k++) tick(1);
        check("rst_tx_reached", {PSEL, PENABLE, PWRITE, PADDR}, {1'b1, 1'b1, 1'b1, 3'd0});
        PRESETn = 1'b0;
        #1;
        check("rst_async", {PSEL, PENABLE, tx_ready}, 0);
        tick(2);
        tx_valid = 1'b0; wait_n = 0; log_q.delete();
        PRESETn = 1'b1;
        for (int k = 0; k < 100 && log_q.size() < 2; k++) tick(1);
        check("reinit_lcr", get(0), {3'd3, 1'b1, 8'h03, 1'b0});
        check("reinit_ier", get(1), {3'd1, 1'b1, IER_EXP, 1'b0});
        tick(5);
        check("rst_no_txr", tx_cnt - t0, 0);
        check("apb_stable", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
